// File: rtl/demux_serial_feeder.sv
// Serialises a parallel word onto d for a 1-to-8 demux, holding the channel select for the whole frame.
module demux_serial_feeder #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_chan,
    output logic              d,
    output logic              s0,
    output logic              s1,
    output logic              s2,
    output logic              busy,
    output logic              frame_start,
    output logic              frame_done
);

    localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] sr_next;
    logic [DATA_W-1:0] sr_shifted;
    logic [2:0]        sel;
    logic [2:0]        sel_next;
    logic              d_next;
    logic              busy_next;
    logic              start_next;
    logic              done_next;
    logic              xfer;

    // Accept only in IDLE; a word offered during SHIFT/GAP waits for the next IDLE edge.
    assign in_ready      = (state == IDLE);
    assign xfer          = in_valid && in_ready;
    assign {s2, s1, s0}  = sel;

    // State and output registers; reset clears d immediately so an aborted frame stops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            sr          <= '0;
            sel         <= 3'b000;
            d           <= 1'b0;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            sr          <= sr_next;
            sel         <= sel_next;
            d           <= d_next;
            busy        <= busy_next;
            frame_start <= start_next;
            frame_done  <= done_next;
        end
    end

    // Next-state and next-output logic; d defaults low so it is 0 outside SHIFT.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sr_next    = sr;
        sel_next   = sel;
        d_next     = 1'b0;
        busy_next  = busy;
        start_next = 1'b0;
        done_next  = 1'b0;
        sr_shifted = LSB_FIRST ? (sr >> 1) : (sr << 1);

        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (xfer) begin
                    state_next = SHIFT;
                    sr_next    = in_data;
                    sel_next   = in_chan;
                    cnt_next   = '0;
                    d_next     = LSB_FIRST ? in_data[0] : in_data[DATA_W-1];
                    busy_next  = 1'b1;
                    start_next = 1'b1;
                end
            end
            SHIFT: begin
                sr_next = sr_shifted;
                if (cnt == CNT_LAST) begin
                    state_next = GAP;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                    d_next   = LSB_FIRST ? sr_shifted[0] : sr_shifted[DATA_W-1];
                end
            end
            GAP: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_demux_serial_feeder.sv
// Bench for demux_serial_feeder: LSB-first and MSB-first instances share stimulus, each checked per cycle.
module tb_demux_serial_feeder;

    localparam int unsigned DW = 8;

    typedef struct packed {
        logic       d;
        logic [2:0] sel;
        logic       busy;
        logic       fs;
        logic       fd;
        logic       rdy;
    } obs_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [2:0]    chan;
        logic [DW-1:0] stream;
        bit            keep;
        bit            scramble;
    } vec_t;

    localparam obs_t RST_OBS = 8'b0_000_0001;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [2:0]    in_chan = '0;

    logic rdy_l, d_l, s0_l, s1_l, s2_l, busy_l, fs_l, fd_l;
    logic rdy_m, d_m, s0_m, s1_m, s2_m, busy_m, fs_m, fd_m;

    obs_t       q_l[$];
    obs_t       q_m[$];
    logic [2:0] last_sel = 3'b000;
    int         tests = 0;
    int         fails = 0;
    int         ntick = 0;

    demux_serial_feeder #(.DATA_W(DW), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_l),
        .in_data(in_data), .in_chan(in_chan), .d(d_l),
        .s0(s0_l), .s1(s1_l), .s2(s2_l),
        .busy(busy_l), .frame_start(fs_l), .frame_done(fd_l)
    );

    demux_serial_feeder #(.DATA_W(DW), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m),
        .in_data(in_data), .in_chan(in_chan), .d(d_m),
        .s0(s0_m), .s1(s1_m), .s2(s2_m),
        .busy(busy_m), .frame_start(fs_m), .frame_done(fd_m)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic obs_t get_l();
        return {d_l, s2_l, s1_l, s0_l, busy_l, fs_l, fd_l, rdy_l};
    endfunction

    function automatic obs_t get_m();
        return {d_m, s2_m, s1_m, s0_m, busy_m, fs_m, fd_m, rdy_m};
    endfunction

    task automatic check(input string name, input int cyc, input obs_t act, input obs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @tick %0d: got %b want %b (d,sel,busy,start,done,ready)",
                     name, cyc, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare both instances against the scoreboard.
    task automatic tick();
        obs_t idle_o;
        obs_t el;
        obs_t em;
        @(negedge clk);
        ntick++;
        if (rst_n) begin
            idle_o = {1'b0, last_sel, 1'b0, 1'b0, 1'b0, 1'b1};
            el = idle_o;
            em = idle_o;
            if (q_l.size() > 0) el = q_l.pop_front();
            if (q_m.size() > 0) em = q_m.pop_front();
            check("lsb_cycle", ntick, get_l(), el);
            check("msb_cycle", ntick, get_m(), em);
        end
    endtask

    // Offer a word, wait for the handshake, and push the expected frame for both bit orders.
    task automatic send(input vec_t v, output int tx);
        bit   ok;
        obs_t e;
        in_valid = 1'b1;
        in_data  = v.data;
        in_chan  = v.chan;
        ok = 1'b0;
        tx = -1;
        for (int n = 0; n < 64; n++) begin
            if (rdy_l === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL handshake_timeout: in_ready=%b, want 1 within 64 cycles", rdy_l);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        tx = ntick;
        for (int k = 0; k < int'(DW); k++) begin
            e = {v.stream[DW-1-k], v.chan, 1'b1, (k == 0), 1'b0, 1'b0};
            q_l.push_back(e);
            e.d = v.data[DW-1-k];
            q_m.push_back(e);
        end
        e = {1'b0, v.chan, 1'b1, 1'b0, 1'b1, 1'b0};
        q_l.push_back(e);
        q_m.push_back(e);
        last_sel = v.chan;
        if (v.scramble) begin
            for (int k = 0; k < int'(DW) + 1; k++) begin
                tick();
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                in_chan  = 3'($urandom);
            end
        end else begin
            tick();
            if (!v.keep) in_valid = 1'b0;
        end
    endtask

    // Main sequence: async reset, table of frames, mid-frame reset, recovery frame.
    initial begin
        vec_t tbl[7];
        vec_t v;
        int   t_prev;
        int   t_now;
        bit   prev_keep;

        tbl[0] = '{8'hA5, 3'd3, 8'b10100101, 1'b0, 1'b0};
        tbl[1] = '{8'h0F, 3'd5, 8'b11110000, 1'b1, 1'b0};
        tbl[2] = '{8'hF0, 3'd6, 8'b00001111, 1'b0, 1'b0};
        tbl[3] = '{8'h81, 3'd7, 8'b10000001, 1'b0, 1'b0};
        tbl[4] = '{8'h3C, 3'd1, 8'b00111100, 1'b0, 1'b1};
        tbl[5] = '{8'h96, 3'd4, 8'b01101001, 1'b0, 1'b1};
        tbl[6] = '{8'h00, 3'd2, 8'b00000000, 1'b0, 1'b0};

        #3 rst_n = 1'b0;
        #1;
        check("reset_async_lsb", ntick, get_l(), RST_OBS);
        check("reset_async_msb", ntick, get_m(), RST_OBS);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        prev_keep = 1'b0;
        t_prev    = 0;
        for (int i = 0; i < 7; i++) begin
            send(tbl[i], t_now);
            if (prev_keep) begin
                tests++;
                if (t_now - t_prev != int'(DW) + 2) begin
                    fails++;
                    $display("FAIL back_to_back_spacing: got %0d cycles want %0d",
                             t_now - t_prev, DW + 2);
                end
            end
            prev_keep = tbl[i].keep;
            t_prev    = t_now;
        end
        repeat (DW + 3) tick();

        v = '{8'hFF, 3'd2, 8'hFF, 1'b0, 1'b0};
        send(v, t_now);
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check("reset_midframe_lsb", ntick, get_l(), RST_OBS);
        check("reset_midframe_msb", ntick, get_m(), RST_OBS);
        q_l.delete();
        q_m.delete();
        last_sel = 3'b000;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        v = '{8'h01, 3'd0, 8'b10000000, 1'b0, 1'b0};
        send(v, t_now);
        repeat (DW + 4) tick();

        tests++;
        if (q_l.size() != 0 || q_m.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left want 0/0",
                     q_l.size(), q_m.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
